adder_driver: RTL and testbench
===============================

# adder_driver

Sequencing front end for the signed 32-bit adder core: accepts operand pairs on a valid/ready input channel, drives the core's two operand inputs, waits the core's fixed latency, and returns the sum (or difference) with a signed-overflow flag on a valid/ready result channel. It sits between the GPIO/processor-facing logic and the adder core. It also handles operand negation, so one add-only core serves both add and subtract.

## Interface
- DATA_W, 32: operand/result width; the core is fixed at 32.
- LATENCY, 0: core latency in clock cycles; 0 = combinational core; legal range 0..4.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operand pair present.
- op_ready  out  1  block can accept an operand pair.
- op_a  in  DATA_W  signed operand A.
- op_b  in  DATA_W  signed operand B.
- op_sub  in  1  0: A+B, 1: A−B.
- add_in_0  out  DATA_W  to core operand 0.
- add_in_1  out  DATA_W  to core operand 1.
- add_out  in  DATA_W  from core sum.
- res_valid  out  1  result present.
- res_ready  in  1  consumer takes result.
- res_data  out  DATA_W  signed result, modulo 2^DATA_W.
- res_ovf  out  1  signed overflow of the requested operation.

## Operation
- FSM states: IDLE, WAIT, HOLD.
- op_ready = (state == IDLE); no other term.
- IDLE:
  - On op_valid && op_ready, register add_in_0 = op_a.
  - Register add_in_1 = op_sub ? (~op_b + 1) : op_b, wrapping, so −INT_MIN = INT_MIN.
  - Latch op_a[31], op_b[31] and op_sub; load wait counter with LATENCY; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter is 0: capture res_data = add_out and res_ovf; go to HOLD.
- HOLD:
  - res_valid = 1; res_data and res_ovf stay stable.
  - On res_ready, go to IDLE.
- Overflow, using s = add_out:
  - Add: ovf = (a[31] == b[31]) && (s[31] != a[31]).
  - Sub: ovf = (a[31] != b[31]) && (s[31] != a[31]).
  - These rules use the original op_b sign, so B = INT_MIN is handled correctly.
- add_in_0/add_in_1 stay stable from the accept edge until the next accept.
- op_* inputs are ignored outside IDLE.
- Reset values:
  - state IDLE, so op_ready = 1.
  - res_valid = 0, res_data = 0, res_ovf = 0.
  - add_in_0 = 0, add_in_1 = 0, counter = 0.
- Reset mid-transaction: the transaction is discarded with no result; the block returns to IDLE.

## Timing
- Accept edge T0.
- res_valid rises at edge T0 + LATENCY + 1.
- Result handshake at the first edge with res_valid && res_ready; op_ready rises after that edge.
- Minimum issue period: LATENCY + 3 cycles (accept, LATENCY+1 cycles in WAIT, one cycle in HOLD).
- res_ready held high: HOLD lasts exactly one cycle.
- res_ready low: result held indefinitely; no loss and no new accept.
- res_ready asserted while not in HOLD: ignored.
- Counter width: clog2(LATENCY+1), minimum 1 bit.

## Structure
- Package adder_pkg contains:
  - DATA_W default constant.
  - INT_MIN / INT_MAX constants.
  - State enum {IDLE, WAIT, HOLD}.
- Sub-module adder_ovf_detect: combinational.
  - Inputs: a_sign, b_sign, s_sign, sub.
  - Output: ovf.
- The adder core is instantiated outside this block by its parent.

## Test plan
- LATENCY=0, res_ready=1: A=5, B=7, add → res_data=12, res_ovf=0; res_valid one cycle after accept; next op_ready after 3 cycles.
- Add overflow: A=0x7FFFFFFF, B=1 → res_data=0x80000000, res_ovf=1. Sub with A=0x80000000, B=1 → res_data=0x7FFFFFFF, res_ovf=1.
- Sub with B=INT_MIN:
  - A=0, B=0x80000000 → add_in_1=0x80000000, res_data=0x80000000, res_ovf=1.
  - A=−1, B=0x80000000 → res_data=0x7FFFFFFF, res_ovf=0.
- LATENCY=3 with a 3-stage core model: 10−3 → res_data=7, res_valid exactly 4 cycles after accept. op_valid toggled during WAIT is not accepted.
- Backpressure: res_ready held 0 for 10 cycles → res_valid, res_data and res_ovf stable, op_ready=0 throughout. After res_ready=1 for one cycle, op_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 in WAIT.
  - Immediately (asynchronous): res_valid=0, add_in_0/add_in_1=0, op_ready=1.
  - After release: a fresh 1+1 yields 2.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and FSM state type for the adder sequencing front end.
// Imported by the driver, its overflow detector and the handshake interface.
package adder_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [DATA_W-1:0] INT_MAX = 32'h7fff_ffff;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/adder_driver_if.sv
// Operand and result valid/ready channels of the adder driver.
// The slave side is the driver; the master side is its producer/consumer.
interface adder_driver_if
  import adder_pkg::*;
#(
  parameter int DATA_W = adder_pkg::DATA_W
);

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_sub;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_ovf;

  modport master (
    output op_valid,
    output op_a,
    output op_b,
    output op_sub,
    output res_ready,
    input  op_ready,
    input  res_valid,
    input  res_data,
    input  res_ovf
  );

  modport slave (
    input  op_valid,
    input  op_a,
    input  op_b,
    input  op_sub,
    input  res_ready,
    output op_ready,
    output res_valid,
    output res_data,
    output res_ovf
  );

endinterface

// File: rtl/adder_ovf_detect.sv
// Signed overflow of A+B or A-B from the operand and sum sign bits.
// b_sign is the original B sign, so B = INT_MIN subtracts correctly.
module adder_ovf_detect
  import adder_pkg::*;
(
  input  logic a_sign,
  input  logic b_sign,
  input  logic s_sign,
  input  logic sub,
  output logic ovf
);

  logic same_dir;

  always_comb begin
    same_dir = sub ? (a_sign != b_sign)
                   : (a_sign == b_sign);
    ovf      = same_dir && (s_sign != a_sign);
  end

endmodule

// File: rtl/adder_driver.sv
// Sequences operand pairs into an add-only core of fixed latency and
// returns sum/difference plus signed overflow on a result channel.
module adder_driver
#(
  parameter int DATA_W  = adder_pkg::DATA_W,
  parameter int LATENCY = 0
)(
  input  logic              clk,
  input  logic              rst_n,
  adder_driver_if.slave     bus,
  output logic [DATA_W-1:0] add_in_0,
  output logic [DATA_W-1:0] add_in_1,
  input  logic [DATA_W-1:0] add_out
);

  import adder_pkg::*;

  localparam int CW =
    (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  state_t            state;
  state_t            nstate;
  logic [CW-1:0]     cnt;
  logic              a_sign;
  logic              b_sign;
  logic              sub_q;
  logic              accept;
  logic              capture;
  logic              ovf;
  logic [DATA_W-1:0] res_q;
  logic              ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (bus.op_valid)     nstate = WAIT;
      WAIT: if (cnt == '0)        nstate = HOLD;
      HOLD: if (bus.res_ready)    nstate = IDLE;
      default:                    nstate = IDLE;
    endcase
  end

  always_comb begin
    bus.op_ready  = (state == IDLE);
    bus.res_valid = (state == HOLD);
    accept        = (state == IDLE) && bus.op_valid;
    capture       = (state == WAIT) && (cnt == '0);
  end

  // Negation wraps, so -INT_MIN feeds INT_MIN to the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_in_0 <= '0;
      add_in_1 <= '0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      sub_q    <= 1'b0;
      cnt      <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        add_in_0 <= bus.op_a;
        add_in_1 <= bus.op_sub
                    ? (~bus.op_b + DATA_W'(1))
                    : bus.op_b;
        a_sign   <= bus.op_a[DATA_W-1];
        b_sign   <= bus.op_b[DATA_W-1];
        sub_q    <= bus.op_sub;
        cnt      <= CW'(LATENCY);
      end else if (state == WAIT
                   && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        res_q <= add_out;
        ovf_q <= ovf;
      end
    end
  end

  adder_ovf_detect u_ovf (
    .a_sign (a_sign),
    .b_sign (b_sign),
    .s_sign (add_out[DATA_W-1]),
    .sub    (sub_q),
    .ovf    (ovf)
  );

  assign bus.res_data = res_q;
  assign bus.res_ovf  = ovf_q;

endmodule

// File: tb/tb_adder_driver.sv
// Bench for adder_driver: LATENCY=0 and LATENCY=3 instances, a timing and
// arithmetic reference model, and directed vectors with literal results.
module tb_adder_driver;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  adder_driver_if #(.DATA_W(32)) if0 ();
  adder_driver_if #(.DATA_W(32)) if3 ();

  logic [31:0] a0_0, a1_0, ao_0;
  logic [31:0] a0_3, a1_3, ao_3;
  logic [31:0] p1 = '0, p2 = '0, p3 = '0;

  logic        op_valid  [2];
  logic [31:0] op_a      [2];
  logic [31:0] op_b      [2];
  logic        op_sub    [2];
  logic        res_ready [2];
  logic        rdy_w     [2];
  logic        vld_w     [2];
  logic [31:0] dat_w     [2];
  logic        ovf_w     [2];
  logic [31:0] in0_w     [2];
  logic [31:0] in1_w     [2];

  assign if0.op_valid  = op_valid[0];
  assign if0.op_a      = op_a[0];
  assign if0.op_b      = op_b[0];
  assign if0.op_sub    = op_sub[0];
  assign if0.res_ready = res_ready[0];
  assign if3.op_valid  = op_valid[1];
  assign if3.op_a      = op_a[1];
  assign if3.op_b      = op_b[1];
  assign if3.op_sub    = op_sub[1];
  assign if3.res_ready = res_ready[1];

  assign rdy_w[0] = if0.op_ready;
  assign vld_w[0] = if0.res_valid;
  assign dat_w[0] = if0.res_data;
  assign ovf_w[0] = if0.res_ovf;
  assign in0_w[0] = a0_0;
  assign in1_w[0] = a1_0;
  assign rdy_w[1] = if3.op_ready;
  assign vld_w[1] = if3.res_valid;
  assign dat_w[1] = if3.res_data;
  assign ovf_w[1] = if3.res_ovf;
  assign in0_w[1] = a0_3;
  assign in1_w[1] = a1_3;

  // Combinational core and a 3-stage pipelined core.
  assign ao_0 = a0_0 + a1_0;
  always @(posedge clk) begin
    p1 <= a0_3 + a1_3;
    p2 <= p1;
    p3 <= p2;
  end
  assign ao_3 = p3;

  adder_driver #(.DATA_W(32), .LATENCY(0)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if0.slave),
    .add_in_0 (a0_0),
    .add_in_1 (a1_0),
    .add_out  (ao_0)
  );

  adder_driver #(.DATA_W(32), .LATENCY(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if3.slave),
    .add_in_0 (a0_3),
    .add_in_1 (a1_3),
    .add_out  (ao_3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%h required=%h t=%0t",
               nm, i, act, exp, $time);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  // Reference model: transaction-level timing plus exact arithmetic.
  longint      cyc = 0;
  bit          m_busy [2];
  longint      m_t0   [2];
  logic [31:0] m_d    [2];
  logic        m_o    [2];
  logic [31:0] m_in0  [2];
  logic [31:0] m_in1  [2];

  always @(posedge clk or negedge rst_n) begin : model
    bit     was;
    longint sa, sb, r;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0;
        m_t0[i]   = 0;
        m_d[i]    = '0;
        m_o[i]    = 1'b0;
        m_in0[i]  = '0;
        m_in1[i]  = '0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        was = m_busy[i];
        if (was && cyc >= m_t0[i] + lat(i) + 2
            && res_ready[i])
          m_busy[i] = 1'b0;
        if (!was && op_valid[i]) begin
          sa = longint'($signed(op_a[i]));
          sb = longint'($signed(op_b[i]));
          r  = op_sub[i] ? sa - sb : sa + sb;
          m_busy[i] = 1'b1;
          m_t0[i]   = cyc;
          m_d[i]    = r[31:0];
          m_o[i]    = (r > 64'sd2147483647)
                   || (r < -64'sd2147483648);
          m_in0[i]  = op_a[i];
          m_in1[i]  = op_sub[i] ? 32'(-sb) : op_b[i];
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit ev;
    for (int i = 0; i < 2; i++) begin
      ev = m_busy[i]
        && (cyc >= m_t0[i] + lat(i) + 1);
      chk("op_ready", i, rdy_w[i], !m_busy[i]);
      chk("res_valid", i, vld_w[i], ev);
      if (ev) begin
        chk("res_data", i, dat_w[i], m_d[i]);
        chk("res_ovf", i, ovf_w[i], m_o[i]);
      end
      chk("add_in_0", i, in0_w[i], m_in0[i]);
      chk("add_in_1", i, in1_w[i], m_in1[i]);
    end
  end

  typedef struct {
    int          i;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    int          stall;
    bit          tog;
    logic [31:0] in1;
    logic [31:0] d;
    logic        o;
    int          lt;
  } vec_t;

  task automatic transact(input vec_t v,
                          output longint acc);
    int n;
    int lt;
    int i;
    i = v.i;
    op_a[i]      = v.a;
    op_b[i]      = v.b;
    op_sub[i]    = v.s;
    op_valid[i]  = 1'b1;
    res_ready[i] = (v.stall == 0);
    n = 0;
    while (!rdy_w[i] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", i, 32'(n < 50), 1);
    @(posedge clk); #1;
    acc = cyc;
    op_valid[i] = 1'b0;
    chk("dir_add_in_1", i, in1_w[i], v.in1);
    lt = 0;
    while (!vld_w[i] && lt < 50) begin
      if (v.tog) begin
        op_valid[i] = lt[0];
        op_a[i]     = 32'h1234_0000 | 32'(lt);
      end
      @(posedge clk); #1;
      lt++;
    end
    op_valid[i] = 1'b0;
    chk("dir_latency", i, 32'(lt), 32'(v.lt));
    chk("dir_res_data", i, dat_w[i], v.d);
    chk("dir_res_ovf", i, ovf_w[i], v.o);
    repeat (v.stall) begin
      @(posedge clk); #1;
      chk("bp_valid", i, vld_w[i], 1);
      chk("bp_data", i, dat_w[i], v.d);
      chk("bp_ovf", i, ovf_w[i], v.o);
      chk("bp_op_ready", i, rdy_w[i], 0);
    end
    res_ready[i] = 1'b1;
    @(posedge clk); #1;
    res_ready[i] = 1'b0;
    chk("ready_after_hs", i, rdy_w[i], 1);
  endtask

  vec_t   vt [8];
  vec_t   vr;
  longint acc;
  longint prev;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      op_valid[i]  = 1'b0;
      op_a[i]      = '0;
      op_b[i]      = '0;
      op_sub[i]    = 1'b0;
      res_ready[i] = 1'b0;
    end
    vt[0] = '{0, 32'd5, 32'd7, 1'b0, 0, 1'b0,
              32'd7, 32'd12, 1'b0, 1};
    vt[1] = '{0, 32'h7fffffff, 32'd1, 1'b0, 0, 1'b0,
              32'd1, 32'h80000000, 1'b1, 1};
    vt[2] = '{0, 32'h80000000, 32'd1, 1'b1, 0, 1'b0,
              32'hffffffff, 32'h7fffffff, 1'b1, 1};
    vt[3] = '{0, 32'd0, 32'h80000000, 1'b1, 0, 1'b0,
              32'h80000000, 32'h80000000, 1'b1, 1};
    vt[4] = '{0, 32'hffffffff, 32'h80000000, 1'b1, 0,
              1'b0, 32'h80000000, 32'h7fffffff, 1'b0, 1};
    vt[5] = '{0, 32'd5, 32'd7, 1'b0, 10, 1'b0,
              32'd7, 32'd12, 1'b0, 1};
    vt[6] = '{1, 32'd10, 32'd3, 1'b1, 0, 1'b1,
              32'hfffffffd, 32'd7, 1'b0, 4};
    vt[7] = '{1, 32'hfffffffb, 32'h7fffffff, 1'b0, 2,
              1'b0, 32'h7fffffff, 32'h7ffffffa, 1'b0, 4};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_op_ready", i, rdy_w[i], 1);
      chk("rst_res_valid", i, vld_w[i], 0);
      chk("rst_res_data", i, dat_w[i], 0);
      chk("rst_res_ovf", i, ovf_w[i], 0);
      chk("rst_add_in_0", i, in0_w[i], 0);
      chk("rst_add_in_1", i, in1_w[i], 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    prev = 0;
    for (int k = 0; k < 8; k++) begin
      transact(vt[k], acc);
      if (k == 1)
        chk("issue_period", 0, 32'(acc - prev), 3);
      prev = acc;
    end

    // Abort a LATENCY=3 transaction with an asynchronous reset in WAIT.
    op_a[1]      = 32'd100;
    op_b[1]      = 32'd200;
    op_sub[1]    = 1'b0;
    op_valid[1]  = 1'b1;
    res_ready[1] = 1'b1;
    @(posedge clk); #1;
    op_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_add_in_0", 1, in0_w[1], 100);
    chk("pre_rst_op_ready", 1, rdy_w[1], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_op_ready", 1, rdy_w[1], 1);
    chk("mid_rst_res_valid", 1, vld_w[1], 0);
    chk("mid_rst_add_in_0", 1, in0_w[1], 0);
    chk("mid_rst_add_in_1", 1, in1_w[1], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_ready[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vr = '{1, 32'd1, 32'd1, 1'b0, 0, 1'b0,
           32'd1, 32'd2, 1'b0, 4};
    transact(vr, acc);
    vr.i  = 0;
    vr.lt = 1;
    transact(vr, acc);
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
